// File: rtl/pc_trace_buffer.sv
// pc_trace_buffer: captures {PC, instruction, ALU result, mem write enable}
// whenever the enabled CPU program counter changes, and queues the records
// in a first-word fall-through FIFO. Captures that arrive while the FIFO is
// full (with no same-cycle pop) are dropped and tallied.
module pc_trace_buffer #(
    parameter int          DEPTH   = 16,
    parameter logic [31:0] INIT_PC = 32'hDEADBEEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  logic [31:0]                PC_out,
    input  logic [31:0]                inst,
    input  logic [31:0]                alu_res,
    input  logic                       mem_wen,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    output logic [31:0]                out_alu,
    output logic                       out_wen,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                drop_cnt
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             CW       = AW + 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    // Drop counter holds at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Entry storage; contents are only meaningful between head and tail.
    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];
    logic [31:0] alu_mem  [DEPTH];
    logic        wen_mem  [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] occ;
    logic [31:0]   pc_last;
    logic          ovf;
    logic [15:0]   drops;

    logic capture;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // Capture qualification and push/pop/drop decisions for this edge.
    always_comb begin
        capture = en && (PC_out != pc_last);
        full    = (occ == FULL_CNT);
        pop     = (occ != '0) && out_ready;
        // A full FIFO still accepts a capture when the head leaves this cycle.
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;
    end

    // Write the captured record at the tail; flush and reset cancel the write.
    always_ff @(posedge clk) begin
        if (push && !rst && !clr) begin
            pc_mem[tail]   <= PC_out;
            inst_mem[tail] <= inst;
            alu_mem[tail]  <= alu_res;
            wen_mem[tail]  <= mem_wen;
        end
    end

    // Control state: pointers, occupancy, last PC, overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            head    <= '0;
            tail    <= '0;
            occ     <= '0;
            pc_last <= INIT_PC;
            ovf     <= 1'b0;
            drops   <= 16'd0;
        end else begin
            if (capture) begin
                pc_last <= PC_out;
            end
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            if (push && !pop) begin
                occ <= occ + CW'(1);
            end else if (pop && !push) begin
                occ <= occ - CW'(1);
            end
            if (drop) begin
                ovf   <= 1'b1;
                drops <= sat_inc16(drops);
            end
        end
    end

    // Head entry falls through straight from storage.
    always_comb begin
        out_valid = (occ != '0);
        out_pc    = pc_mem[head];
        out_inst  = inst_mem[head];
        out_alu   = alu_mem[head];
        out_wen   = wen_mem[head];
        count     = occ;
        overflow  = ovf;
        drop_cnt  = drops;
    end

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Self-checking bench for pc_trace_buffer: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_pc_trace_buffer;

    localparam int          DEPTH   = 16;
    localparam logic [31:0] INIT_PC = 32'hDEADBEEF;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clr;
    logic [31:0] PC_out;
    logic [31:0] inst;
    logic [31:0] alu_res;
    logic        mem_wen;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] out_alu;
    logic        out_wen;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    pc_trace_buffer #(.DEPTH(DEPTH), .INIT_PC(INIT_PC)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .PC_out(PC_out), .inst(inst), .alu_res(alu_res), .mem_wen(mem_wen),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_alu(out_alu), .out_wen(out_wen),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] alu;
        logic        wen;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc_last;
    logic        m_ovf;
    int          m_drops;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare all observable outputs against the model (called at negedge).
    task automatic check_outputs();
        check_eq("valid", out_valid, q.size() != 0);
        check_eq("count", count, q.size());
        check_eq("overflow", overflow, m_ovf);
        check_eq("drop_cnt", drop_cnt, m_drops);
        if (q.size() != 0) begin
            check_eq("head_pc", out_pc, q[0].pc);
            check_eq("head_inst", out_inst, q[0].inst);
            check_eq("head_alu", out_alu, q[0].alu);
            check_eq("head_wen", out_wen, q[0].wen);
        end
    endtask

    // One clock: drive inputs, optionally check, advance the model across the edge.
    task automatic step(input logic r, input logic c, input logic e,
                        input logic [31:0] pc, input logic rdy, input bit do_chk);
        ent_t n;
        bit   p_pop;
        bit   p_cap;
        rst       = r;
        clr       = c;
        en        = e;
        PC_out    = pc;
        out_ready = rdy;
        inst      = $urandom;
        alu_res   = $urandom;
        mem_wen   = 1'($urandom);
        if (do_chk) check_outputs();
        if (r || c) begin
            q.delete();
            m_pc_last = INIT_PC;
            m_ovf     = 1'b0;
            m_drops   = 0;
        end else begin
            p_pop = (q.size() != 0) && rdy;
            p_cap = e && (pc != m_pc_last);
            n.pc = pc; n.inst = inst; n.alu = alu_res; n.wen = mem_wen;
            if (p_cap) m_pc_last = pc;
            if (p_cap && q.size() == DEPTH && !p_pop) begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
            if (p_pop) void'(q.pop_front());
            if (p_cap && (q.size() < DEPTH)) q.push_back(n);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] seq [5];
        m_pc_last = INIT_PC;
        m_ovf     = 1'b0;
        m_drops   = 0;

        // Reset state
        do_reset();
        check_eq("rst_count", count, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_drops", drop_cnt, 0);

        // Basic capture: 0,0,4,4,8
        seq = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8};
        foreach (seq[i]) step(1'b0, 1'b0, 1'b1, seq[i], 1'b0, 1'b1);
        check_eq("basic_count", count, 3);
        check_eq("basic_pc0", out_pc, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h8, 1'b1, 1'b1);
        check_eq("basic_pc1", out_pc, 32'h4);
        step(1'b0, 1'b0, 1'b0, 32'h8, 1'b1, 1'b1);
        check_eq("basic_pc2", out_pc, 32'h8);
        step(1'b0, 1'b0, 1'b0, 32'h8, 1'b1, 1'b1);
        check_eq("basic_empty", out_valid, 0);

        // Overflow: 18 distinct PCs into a 16-deep FIFO
        do_reset();
        for (int i = 0; i < 18; i++) step(1'b0, 1'b0, 1'b1, 32'h100 + 32'(i) * 4, 1'b0, 1'b1);
        check_eq("ovf_count", count, 16);
        check_eq("ovf_flag", overflow, 1);
        check_eq("ovf_drops", drop_cnt, 2);
        check_eq("ovf_head", out_pc, 32'h100);

        // Full with simultaneous capture and pop
        step(1'b0, 1'b0, 1'b1, 32'h5000, 1'b1, 1'b1);
        check_eq("fullsim_count", count, 16);
        check_eq("fullsim_drops", drop_cnt, 2);
        check_eq("fullsim_head", out_pc, 32'h104);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0, 32'h5000, 1'b1, 1'b1);
        check_eq("fullsim_tail", out_pc, 32'h5000);
        step(1'b0, 1'b0, 1'b0, 32'h5000, 1'b1, 1'b1);
        check_eq("fullsim_empty", count, 0);
        check_eq("ovf_sticky", overflow, 1);

        // Enable gating
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h4, 1'b0, 1'b1);
        check_eq("gate_none", count, 0);
        step(1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 1'b1);
        check_eq("gate_count", count, 1);
        check_eq("gate_pc", out_pc, 32'h4);

        // Clear versus same-cycle capture, with count=5 and overflow set
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b1, 32'h200 + 32'(i) * 4, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("clr_pre_count", count, 5);
        check_eq("clr_pre_ovf", overflow, 1);
        step(1'b0, 1'b1, 1'b1, 32'h7777, 1'b1, 1'b1);
        check_eq("clr_count", count, 0);
        check_eq("clr_ovf", overflow, 0);
        check_eq("clr_drops", drop_cnt, 0);
        step(1'b0, 1'b0, 1'b1, 32'h7777, 1'b0, 1'b1);
        check_eq("clr_recap", count, 1);
        check_eq("clr_recap_pc", out_pc, 32'h7777);

        // Wrap-around with continuous pop
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h1000 + 32'(i) * 4, 1'b1, 1'b1);
            check_eq("wrap_le1", count <= 1, 1);
        end
        check_eq("wrap_drops", drop_cnt, 0);
        check_eq("wrap_last", out_pc, 32'h1000 + 39 * 4);

        // Random traffic with a small PC pool so repeats occur
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 399) == 0), ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0), 32'($urandom_range(0, 5)) * 4,
                 ($urandom_range(0, 2) == 0), 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
